// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - big-endian data memory with cycle counter, console FIFO, halt and status MMIO
module dmem_responder #(
  parameter int          DEPTH_WORDS   = 1024,
  parameter logic [31:0] MMIO_BASE     = 32'hFFFF_0000,
  parameter int          CONSOLE_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [0:31] addr_to_mem,
  input  logic        write_enable_to_mem,
  input  logic        byte_to_mem,
  input  logic        half_word_to_mem,
  input  logic        sign_extend_to_mem,
  input  logic [0:31] data_to_mem,
  output logic [0:31] data_from_mem,
  output logic        console_valid,
  output logic [0:7]  console_data,
  input  logic        console_ready,
  output logic        halt,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int FW = $clog2(CONSOLE_DEPTH);

  // Bus values renumbered so that index 0 is the LSB; positional assignment
  // maps the big-endian MSB (bit 0) onto bit 31 here.
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  assign addr          = addr_to_mem;
  assign wdata         = data_to_mem;
  assign data_from_mem = rdata;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [7:0]  fifo_q [CONSOLE_DEPTH];

  logic [31:0]  cnt_q, cnt_d;
  logic [FW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FW:0]   count_q, count_d;
  logic          halt_q, halt_d;
  logic          misaligned_q, misaligned_d;
  logic          overflow_q, overflow_d;

  logic          is_mmio;
  logic          mis;
  logic [1:0]    lane;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [31:0]   merged;
  logic          mem_wr_en;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;

  // Address decode: MMIO window match, word index and alignment check
  always_comb begin
    is_mmio  = (addr[31:4] == MMIO_BASE[31:4]);
    lane     = addr[1:0];
    word_idx = addr[AW+1:2];
    rd_word  = mem_q[word_idx];
    mis      = 1'b0;
    if (!is_mmio && !byte_to_mem) begin
      if (half_word_to_mem) mis = addr[0];
      else                  mis = (addr[1:0] != 2'b00);
    end
  end

  // FIFO status flags
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == (FW+1)'(CONSOLE_DEPTH));
  end

  // Load path: MMIO registers or the extracted, extended array lane
  always_comb begin
    rdata = '0;
    sel_byte = 8'h00;
    sel_half = 16'h0000;
    case (lane)
      2'd0:    sel_byte = rd_word[31:24];
      2'd1:    sel_byte = rd_word[23:16];
      2'd2:    sel_byte = rd_word[15:8];
      default: sel_byte = rd_word[7:0];
    endcase
    sel_half = addr[1] ? rd_word[15:0] : rd_word[31:16];
    if (is_mmio) begin
      case (addr[3:2])
        2'd0:    rdata = cnt_q;
        2'd1:    rdata = {{(31-FW){1'b0}}, count_q};
        2'd2:    rdata = {31'b0, halt_q};
        default: rdata = {28'b0, overflow_q, misaligned_q, fifo_full, fifo_empty};
      endcase
    end else if (mis) begin
      rdata = '0;
    end else if (byte_to_mem) begin
      rdata = {{24{sign_extend_to_mem & sel_byte[7]}}, sel_byte};
    end else if (half_word_to_mem) begin
      rdata = {{16{sign_extend_to_mem & sel_half[15]}}, sel_half};
    end else begin
      rdata = rd_word;
    end
  end

  // Store path: merge the addressed lane into the current word
  always_comb begin
    merged = rd_word;
    if (byte_to_mem) begin
      case (lane)
        2'd0:    merged[31:24] = wdata[7:0];
        2'd1:    merged[23:16] = wdata[7:0];
        2'd2:    merged[15:8]  = wdata[7:0];
        default: merged[7:0]   = wdata[7:0];
      endcase
    end else if (half_word_to_mem) begin
      if (addr[1]) merged[15:0]  = wdata[15:0];
      else         merged[31:16] = wdata[15:0];
    end else begin
      merged = wdata;
    end
    mem_wr_en = write_enable_to_mem && !is_mmio && !mis && !halt_q;
  end

  // Next-state for counter, console FIFO and sticky flags
  always_comb begin
    cnt_d        = cnt_q + 32'd1;
    pop          = !fifo_empty && console_ready;
    push_req     = write_enable_to_mem && is_mmio && (addr[3:2] == 2'd1) && !halt_q;
    // A push into a full FIFO is only accepted when a pop frees the head slot
    push         = push_req && (!fifo_full || pop);
    rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d      = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    overflow_d   = overflow_q | (push_req && !push);
    halt_d       = halt_q | (write_enable_to_mem && is_mmio && (addr[3:2] == 2'd2));
    misaligned_d = misaligned_q | mis;
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      halt_q       <= 1'b0;
      misaligned_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      halt_q       <= halt_d;
      misaligned_q <= misaligned_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage arrays are not reset; writes in a reset cycle are discarded
  always_ff @(posedge clock) begin
    if (reset && mem_wr_en) mem_q[word_idx] <= merged;
    if (reset && push)      fifo_q[wr_ptr_q] <= wdata[7:0];
  end

  assign console_valid = !fifo_empty;
  assign console_data  = fifo_q[rd_ptr_q];
  assign halt          = halt_q;
  assign misaligned    = misaligned_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clock;
  logic        reset;
  logic [0:31] addr_to_mem;
  logic        write_enable_to_mem;
  logic        byte_to_mem;
  logic        half_word_to_mem;
  logic        sign_extend_to_mem;
  logic [0:31] data_to_mem;
  logic [0:31] data_from_mem;
  logic        console_valid;
  logic [0:7]  console_data;
  logic        console_ready;
  logic        halt;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .MMIO_BASE(32'hFFFF_0000),
    .CONSOLE_DEPTH(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .addr_to_mem(addr_to_mem),
    .write_enable_to_mem(write_enable_to_mem),
    .byte_to_mem(byte_to_mem),
    .half_word_to_mem(half_word_to_mem),
    .sign_extend_to_mem(sign_extend_to_mem),
    .data_to_mem(data_to_mem),
    .data_from_mem(data_from_mem),
    .console_valid(console_valid),
    .console_data(console_data),
    .console_ready(console_ready),
    .halt(halt),
    .misaligned(misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic        bt;
    logic        hw;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_bus(input logic we, input logic bt, input logic hw, input logic sx,
                         input logic [31:0] a, input logic [31:0] d);
    write_enable_to_mem = we;
    byte_to_mem         = bt;
    half_word_to_mem    = hw;
    sign_extend_to_mem  = sx;
    addr_to_mem         = a;
    data_to_mem         = d;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mmio_read(input string name, input logic [3:0] off, input logic [31:0] exp);
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, MB | {28'b0, off}, 32'h0);
    #1;
    check(name, data_from_mem, exp);
    tick();
  endtask

  logic [31:0] c0;
  logic [31:0] c1;

  initial begin
    reset = 1'b0;
    console_ready = 1'b0;
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    check("rst_halt", {31'b0, halt}, 32'h0);
    check("rst_misaligned", {31'b0, misaligned}, 32'h0);
    check("rst_console_valid", {31'b0, console_valid}, 32'h0);
    mmio_read("rst_cycle", 4'h0, 32'h0);

    //              we    bt    hw    sx    addr           data           chk   exp
    vt.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0014, 32'h1111_2222, 1'b0, 32'h0});
    vt.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h8123_45F6, 1'b0, 32'h0});
    vt.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0013, 32'h0,         1'b1, 32'hFFFF_FFF6});
    vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0000_00F6});
    vt.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0,         1'b1, 32'hFFFF_8123});
    vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h0000_8123});
    vt.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0011, 32'h0000_00AA, 1'b0, 32'h0});
    vt.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0012, 32'h0000_BEEF, 1'b0, 32'h0});
    vt.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h81AA_BEEF});
    vt.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0011, 32'h0,         1'b1, 32'hFFFF_FFAA});
    vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'h0000_BEEF});
    vt.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1010, 32'h0,         1'b1, 32'h81AA_BEEF});
    vt.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0102_0304, 1'b1, 32'h81AA_BEEF});
    vt.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h0102_0304});
    vt.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0014, 32'h0,         1'b1, 32'h1111_2222});
    vt.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0016, 32'hDEAD_BEEF, 1'b0, 32'h0});
    vt.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0014, 32'h0,         1'b1, 32'h1111_2222});
    vt.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0016, 32'h0,         1'b1, 32'h0});
    vt.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0013, 32'h0,         1'b1, 32'h0});
    vt.push_back('{1'b0, 1'b0, 1'b0, 1'b0, MB | 32'hC,    32'h0,         1'b1, 32'h0000_0005});

    for (int i = 0; i < vt.size(); i++) begin
      set_bus(vt[i].we, vt[i].bt, vt[i].hw, vt[i].sx, vt[i].addr, vt[i].data);
      #1;
      if (vt[i].chk) check($sformatf("vec%0d", i), data_from_mem, vt[i].exp);
      tick();
    end
    check("misaligned_flag", {31'b0, misaligned}, 32'h1);

    // Console overflow: nine pushes with the sink stalled
    for (int i = 0; i < 9; i++) begin
      set_bus(1'b1, 1'b0, 1'b0, 1'b0, MB | 32'h4, 32'h41 + i);
      tick();
      if (i == 0) begin
        check("first_valid", {31'b0, console_valid}, 32'h1);
        check("first_head", {24'b0, console_data}, 32'h41);
      end
    end
    mmio_read("occ_full", 4'h4, 32'h8);
    mmio_read("status_ovf", 4'hC, 32'h0000_000E);
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    console_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("drain_valid%0d", i), {31'b0, console_valid}, 32'h1);
      check($sformatf("drain_data%0d", i), {24'b0, console_data}, 32'h41 + i);
      tick();
    end
    check("drained_empty", {31'b0, console_valid}, 32'h0);
    console_ready = 1'b0;

    // Push and pop together on a full FIFO
    for (int i = 0; i < 8; i++) begin
      set_bus(1'b1, 1'b0, 1'b0, 1'b0, MB | 32'h4, 32'h61 + i);
      tick();
    end
    set_bus(1'b1, 1'b0, 1'b0, 1'b0, MB | 32'h4, 32'h5A);
    console_ready = 1'b1;
    #1;
    check("full_pp_head", {24'b0, console_data}, 32'h61);
    tick();
    console_ready = 1'b0;
    mmio_read("full_pp_occ", 4'h4, 32'h8);
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    console_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("pp_data%0d", i), {24'b0, console_data}, (i == 7) ? 32'h5A : 32'h62 + i);
      tick();
    end
    check("pp_empty", {31'b0, console_valid}, 32'h0);
    console_ready = 1'b0;

    // Halt suppresses stores; reset clears state and drops queued bytes
    set_bus(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h1234_5678);
    tick();
    set_bus(1'b1, 1'b0, 1'b0, 1'b0, MB | 32'h4, 32'h71);
    tick();
    set_bus(1'b1, 1'b0, 1'b0, 1'b0, MB | 32'h4, 32'h72);
    tick();
    set_bus(1'b1, 1'b0, 1'b0, 1'b0, MB | 32'h8, 32'h0);
    tick();
    check("halt_set", {31'b0, halt}, 32'h1);
    set_bus(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h9999_9999);
    tick();
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
    #1;
    check("halt_store_blocked", data_from_mem, 32'h1234_5678);
    tick();
    set_bus(1'b1, 1'b0, 1'b0, 1'b0, MB | 32'h4, 32'h73);
    tick();
    mmio_read("halt_push_blocked", 4'h4, 32'h2);
    mmio_read("halt_read", 4'h8, 32'h1);
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, MB, 32'h0);
    #1;
    c0 = data_from_mem;
    tick();
    #1;
    c1 = data_from_mem;
    check("cycle_step", c1, c0 + 32'd1);
    tick();

    reset = 1'b0;
    set_bus(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'hBBBB_BBBB);
    tick();
    reset = 1'b1;
    check("post_rst_halt", {31'b0, halt}, 32'h0);
    check("post_rst_misaligned", {31'b0, misaligned}, 32'h0);
    check("post_rst_valid", {31'b0, console_valid}, 32'h0);
    mmio_read("post_rst_cycle", 4'h0, 32'h0);
    mmio_read("post_rst_occ", 4'h4, 32'h0);
    mmio_read("post_rst_status", 4'hC, 32'h1);
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
    #1;
    check("rst_store_discarded", data_from_mem, 32'h1234_5678);
    tick();
    set_bus(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'hCAFE_F00D);
    tick();
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
    #1;
    check("store_after_rst", data_from_mem, 32'hCAFE_F00D);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
